my_ep_mem_ctrl: RTL and testbench

//  PCIe endpoint (PIO-style) memory/completion controller between the RX engine and the TX engine.
//  - Holds a DW-addressed target memory: RX-engine writes go in through a busy-handshaked write port.
//  - The TX engine reads it back through a combinational read port.
//  - Latches completion requests from the RX engine and forwards them to the TX engine.
//  - Tracks each completion until the TX engine reports it done, and throttles non-posted traffic meanwhile.

---
 rtl/my_ep_mem_pkg.sv | 36 +++
 rtl/cmd_process_fsm.sv | 83 ++++++++
 rtl/my_ep_mem_ctrl.sv | 138 +++++++++++++
 tb/tb_my_ep_mem_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/my_ep_mem_pkg.sv
// Shared types and constants for the endpoint memory/completion controller.
//   ADDR_W/DATA_W  : DW address width and DW data width
//   MEM_DEPTH      : number of DW entries in the target memory
//   ADDR0_DW       : DW address of the first software-visible register
//   state_t        : completion FSM states
//   req_hdr_t      : latched completion request header
package my_ep_mem_pkg;

   localparam int unsigned ADDR_W    = 11;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned MEM_DEPTH = 2 ** ADDR_W;
   localparam int unsigned BYTES_W   = DATA_W / 8;
   localparam int unsigned WR_BE_W   = 8;
   localparam int unsigned ADDR0_DW  = 16;

   typedef enum logic [1:0] {
      STATE_IDLE         = 2'd0,
      STATE_SEND_CPL     = 2'd1,
      STATE_WAIT_TX_CPLT = 2'd2
   } state_t;

   typedef struct packed {
      logic [1:0]  cmd_id;
      logic        with_data;
      logic [2:0]  tc;
      logic        td;
      logic        ep;
      logic [1:0]  attr;
      logic [9:0]  len;
      logic [15:0] rid;
      logic [7:0]  tag;
      logic [7:0]  be;
      logic [12:0] addr;
   } req_hdr_t;

endpackage

// File: rtl/cmd_process_fsm.sv
// Completion tracking FSM: latches a completion request, issues a one-cycle
// start pulse to the TX engine, then holds the header until the TX engine
// reports the completion sent.
//   clk, rst_n           : clock, async active-low reset
//   req_compl_i          : completion request pulse from RX engine
//   txe_compl_done_i     : completion-sent pulse from TX engine
//   hdr_i / hdr_o        : request header in / latched header out
//   req_compl_o          : start-completion pulse to TX engine
//   to_rxe_compl_done_o  : completion-finished pulse to RX engine
//   rx_np_ok             : 1 while a new non-posted request may be accepted
module cmd_process_fsm
   import my_ep_mem_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     req_compl_i,
   input  logic     txe_compl_done_i,
   input  req_hdr_t hdr_i,
   output req_hdr_t hdr_o,
   output logic     req_compl_o,
   output logic     to_rxe_compl_done_o,
   output logic     rx_np_ok
);

   state_t   state;
   state_t   state_next;
   req_hdr_t hdr_next;
   logic     req_compl_next;
   logic     done_next;
   logic     np_ok_next;

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state               <= STATE_IDLE;
         hdr_o               <= '0;
         req_compl_o         <= 1'b0;
         to_rxe_compl_done_o <= 1'b0;
         rx_np_ok            <= 1'b1;
      end else begin
         state               <= state_next;
         hdr_o               <= hdr_next;
         req_compl_o         <= req_compl_next;
         to_rxe_compl_done_o <= done_next;
         rx_np_ok            <= np_ok_next;
      end
   end

   // Next state and next registered outputs; cmd_id only feeds the header
   // latch, so it cannot disturb the state or rx_np_ok.
   always_comb begin
      state_next     = state;
      hdr_next       = hdr_o;
      req_compl_next = 1'b0;
      done_next      = 1'b0;
      np_ok_next     = rx_np_ok;
      case (state)
         STATE_IDLE: begin
            if (req_compl_i) begin
               hdr_next       = hdr_i;
               req_compl_next = 1'b1;
               np_ok_next     = 1'b0;
               state_next     = STATE_SEND_CPL;
            end
         end
         STATE_SEND_CPL: begin
            state_next = STATE_WAIT_TX_CPLT;
         end
         STATE_WAIT_TX_CPLT: begin
            if (txe_compl_done_i) begin
               done_next  = 1'b1;
               np_ok_next = 1'b1;
               state_next = STATE_IDLE;
            end
         end
         default: begin
            state_next = STATE_IDLE;
            np_ok_next = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/my_ep_mem_ctrl.sv
// PIO endpoint memory/completion controller between RX and TX engines.
//   clk, rst_n                 : clock, async active-low reset
//   rx_np_ok                   : may accept a new non-posted request
//   cmd_id_i, req_*_i          : completion request class and header fields
//   req_compl_i / req_compl_o  : completion request in / start pulse to TX
//   req_compl_with_data_o      : latched CplD flag
//   txe_compl_done_i           : completion sent (from TX)
//   to_rxe_compl_done_o        : completion finished (to RX)
//   rd_addr_i, rd_be_i, rd_data_o : combinational byte-masked DW read port
//   wr_addr_i, wr_be_i, wr_data_i, wr_en_i, wr_busy_o : two-cycle write port
module my_ep_mem_ctrl
   import my_ep_mem_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   output logic              rx_np_ok,
   input  logic [1:0]        cmd_id_i,
   input  logic              req_compl_i,
   input  logic              req_compl_with_data_i,
   output logic              to_rxe_compl_done_o,
   input  logic [2:0]        req_tc_i,
   input  logic              req_td_i,
   input  logic              req_ep_i,
   input  logic [1:0]        req_attr_i,
   input  logic [9:0]        req_len_i,
   input  logic [15:0]       req_rid_i,
   input  logic [7:0]        req_tag_i,
   input  logic [7:0]        req_be_i,
   input  logic [12:0]       req_addr_i,
   output logic              req_compl_o,
   output logic              req_compl_with_data_o,
   input  logic              txe_compl_done_i,
   output logic [2:0]        req_tc_o,
   output logic              req_td_o,
   output logic              req_ep_o,
   output logic [1:0]        req_attr_o,
   output logic [9:0]        req_len_o,
   output logic [15:0]       req_rid_o,
   output logic [7:0]        req_tag_o,
   output logic [7:0]        req_be_o,
   output logic [12:0]       req_addr_o,
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic [BYTES_W-1:0] rd_be_i,
   output logic [DATA_W-1:0] rd_data_o,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [WR_BE_W-1:0] wr_be_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              wr_en_i,
   output logic              wr_busy_o
);

   // Target memory; zero at time 0, never reset.
   logic [DATA_W-1:0] mem [MEM_DEPTH] = '{default: '0};

   logic [ADDR_W-1:0]  wr_addr_q;
   logic [BYTES_W-1:0] wr_be_q;
   logic [DATA_W-1:0]  wr_data_q;
   logic [DATA_W-1:0]  rd_word;
   req_hdr_t           hdr_in;
   req_hdr_t           hdr_out;
   logic               unused_bits;

   // Upper write byte enables and the latched class tag have no consumer here.
   assign unused_bits = ^{wr_be_i[WR_BE_W-1:BYTES_W], hdr_out.cmd_id};

   // Write capture: accept a strobe only when idle, commit on the next edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_busy_o <= 1'b0;
         wr_addr_q <= '0;
         wr_be_q   <= '0;
         wr_data_q <= '0;
      end else if (wr_busy_o) begin
         wr_busy_o <= 1'b0;
      end else if (wr_en_i) begin
         wr_busy_o <= 1'b1;
         wr_addr_q <= wr_addr_i;
         wr_be_q   <= wr_be_i[BYTES_W-1:0];
         wr_data_q <= wr_data_i;
      end
   end

   // Byte-masked commit of the captured write
   always_ff @(posedge clk) begin
      if (wr_busy_o) begin
         for (int k = 0; k < int'(BYTES_W); k++) begin
            if (wr_be_q[k]) mem[wr_addr_q][8*k +: 8] <= wr_data_q[8*k +: 8];
         end
      end
   end

   // Zero-latency read with disabled byte lanes forced to zero
   always_comb begin
      rd_word   = mem[rd_addr_i];
      rd_data_o = '0;
      for (int k = 0; k < int'(BYTES_W); k++) begin
         rd_data_o[8*k +: 8] = rd_be_i[k] ? rd_word[8*k +: 8] : 8'h00;
      end
   end

   always_comb begin
      hdr_in.cmd_id    = cmd_id_i;
      hdr_in.with_data = req_compl_with_data_i;
      hdr_in.tc        = req_tc_i;
      hdr_in.td        = req_td_i;
      hdr_in.ep        = req_ep_i;
      hdr_in.attr      = req_attr_i;
      hdr_in.len       = req_len_i;
      hdr_in.rid       = req_rid_i;
      hdr_in.tag       = req_tag_i;
      hdr_in.be        = req_be_i;
      hdr_in.addr      = req_addr_i;
   end

   cmd_process_fsm cmd_process_fsm_inst (
      .clk                 (clk),
      .rst_n               (rst_n),
      .req_compl_i         (req_compl_i),
      .txe_compl_done_i    (txe_compl_done_i),
      .hdr_i               (hdr_in),
      .hdr_o               (hdr_out),
      .req_compl_o         (req_compl_o),
      .to_rxe_compl_done_o (to_rxe_compl_done_o),
      .rx_np_ok            (rx_np_ok)
   );

   assign req_compl_with_data_o = hdr_out.with_data;
   assign req_tc_o              = hdr_out.tc;
   assign req_td_o              = hdr_out.td;
   assign req_ep_o              = hdr_out.ep;
   assign req_attr_o            = hdr_out.attr;
   assign req_len_o             = hdr_out.len;
   assign req_rid_o             = hdr_out.rid;
   assign req_tag_o             = hdr_out.tag;
   assign req_be_o              = hdr_out.be;
   assign req_addr_o            = hdr_out.addr;

endmodule

// File: tb/tb_my_ep_mem_ctrl.sv
// Scoreboard bench for my_ep_mem_ctrl: memory write/read port and the
// completion request/done handshake.
module tb_my_ep_mem_ctrl;
   import my_ep_mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_np_ok;
   logic [1:0]  cmd_id_i;
   logic        req_compl_i, req_compl_with_data_i, to_rxe_compl_done_o;
   logic [2:0]  req_tc_i, req_tc_o;
   logic        req_td_i, req_td_o, req_ep_i, req_ep_o;
   logic [1:0]  req_attr_i, req_attr_o;
   logic [9:0]  req_len_i, req_len_o;
   logic [15:0] req_rid_i, req_rid_o;
   logic [7:0]  req_tag_i, req_tag_o, req_be_i, req_be_o;
   logic [12:0] req_addr_i, req_addr_o;
   logic        req_compl_o, req_compl_with_data_o, txe_compl_done_i;
   logic [10:0] rd_addr_i, wr_addr_i;
   logic [3:0]  rd_be_i;
   logic [31:0] rd_data_o, wr_data_i;
   logic [7:0]  wr_be_i;
   logic        wr_en_i, wr_busy_o;

   int n_checks = 0;
   int n_errors = 0;
   int cpl_pulses = 0;
   int done_pulses = 0;

   logic [63:0] cpl_q [$];
   logic [31:0] rd_q [$];
   logic [31:0] model [2048];

   always #5 clk = ~clk;

   my_ep_mem_ctrl dut (
      .clk(clk), .rst_n(rst_n), .rx_np_ok(rx_np_ok), .cmd_id_i(cmd_id_i),
      .req_compl_i(req_compl_i), .req_compl_with_data_i(req_compl_with_data_i),
      .to_rxe_compl_done_o(to_rxe_compl_done_o),
      .req_tc_i(req_tc_i), .req_td_i(req_td_i), .req_ep_i(req_ep_i), .req_attr_i(req_attr_i),
      .req_len_i(req_len_i), .req_rid_i(req_rid_i), .req_tag_i(req_tag_i), .req_be_i(req_be_i),
      .req_addr_i(req_addr_i), .req_compl_o(req_compl_o),
      .req_compl_with_data_o(req_compl_with_data_o), .txe_compl_done_i(txe_compl_done_i),
      .req_tc_o(req_tc_o), .req_td_o(req_td_o), .req_ep_o(req_ep_o), .req_attr_o(req_attr_o),
      .req_len_o(req_len_o), .req_rid_o(req_rid_o), .req_tag_o(req_tag_o), .req_be_o(req_be_o),
      .req_addr_o(req_addr_o),
      .rd_addr_i(rd_addr_i), .rd_be_i(rd_be_i), .rd_data_o(rd_data_o),
      .wr_addr_i(wr_addr_i), .wr_be_i(wr_be_i), .wr_data_i(wr_data_i), .wr_en_i(wr_en_i),
      .wr_busy_o(wr_busy_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] pack_hdr(input logic [2:0] tc, input logic td, input logic ep,
                                            input logic [1:0] attr, input logic [9:0] len,
                                            input logic [15:0] rid, input logic [7:0] tag,
                                            input logic [7:0] be, input logic [12:0] addr,
                                            input logic wd);
      return {1'b0, tc, td, ep, attr, len, rid, tag, be, addr, wd};
   endfunction

   function automatic logic [31:0] exp_rd(input logic [10:0] a, input logic [3:0] be);
      logic [31:0] w;
      w = model[a];
      for (int k = 0; k < 4; k++) if (!be[k]) w[8*k +: 8] = 8'h00;
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Completion start monitor: each pulse pops one expected header.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && req_compl_o === 1'b1) begin
         cpl_pulses++;
         if (cpl_q.size() == 0) check("cpl_unexpected", 64'(req_compl_o), 64'd0);
         else check("cpl_hdr", pack_hdr(req_tc_o, req_td_o, req_ep_o, req_attr_o, req_len_o,
                                        req_rid_o, req_tag_o, req_be_o, req_addr_o,
                                        req_compl_with_data_o), cpl_q.pop_front());
      end
      if (rst_n === 1'b1 && to_rxe_compl_done_o === 1'b1) done_pulses++;
   end

   task automatic do_write(input logic [10:0] a, input logic [7:0] be, input logic [31:0] d);
      int n;
      wr_addr_i = a; wr_be_i = be; wr_data_i = d; wr_en_i = 1'b1;
      tick();
      wr_en_i = 1'b0;
      check("wr_busy_set", 64'(wr_busy_o), 64'd1);
      n = 0;
      while (wr_busy_o && n < 8) begin
         tick();
         n++;
      end
      check("wr_latency", 64'(n), 64'd1);
      for (int k = 0; k < 4; k++) if (be[k]) model[a][8*k +: 8] = d[8*k +: 8];
   endtask

   task automatic do_read(input logic [10:0] a, input logic [3:0] be, input logic [31:0] exp);
      rd_addr_i = a; rd_be_i = be;
      rd_q.push_back(exp);
      tick();
      check($sformatf("rd@%0d/be%0h", a, be), 64'(rd_data_o), 64'(rd_q.pop_front()));
   endtask

   task automatic send_req(input logic [2:0] tc, input logic td, input logic ep,
                           input logic [1:0] attr, input logic [9:0] len, input logic [15:0] rid,
                           input logic [7:0] tag, input logic [7:0] be, input logic [12:0] addr,
                           input logic wd, input logic accepted);
      req_tc_i = tc; req_td_i = td; req_ep_i = ep; req_attr_i = attr; req_len_i = len;
      req_rid_i = rid; req_tag_i = tag; req_be_i = be; req_addr_i = addr;
      req_compl_with_data_i = wd; cmd_id_i = 2'($urandom_range(3)); req_compl_i = 1'b1;
      if (accepted) cpl_q.push_back(pack_hdr(tc, td, ep, attr, len, rid, tag, be, addr, wd));
      tick();
      req_compl_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [10:0] addrs [6];
      logic [3:0]  rbe;
      logic [31:0] d16;

      foreach (model[i]) model[i] = 32'h0;
      rst_n = 1'b0; cmd_id_i = '0; req_compl_i = 0; req_compl_with_data_i = 0;
      req_tc_i = '0; req_td_i = 0; req_ep_i = 0; req_attr_i = '0; req_len_i = '0;
      req_rid_i = '0; req_tag_i = '0; req_be_i = '0; req_addr_i = '0; txe_compl_done_i = 0;
      rd_addr_i = '0; rd_be_i = '0; wr_addr_i = '0; wr_be_i = '0; wr_data_i = '0; wr_en_i = 0;
      repeat (3) tick();

      // Reset values
      check("rst_state", 64'(dut.cmd_process_fsm_inst.state), 64'(STATE_IDLE));
      check("rst_np_ok", 64'(rx_np_ok), 64'd1);
      check("rst_cpl", 64'(req_compl_o), 64'd0);
      check("rst_done", 64'(to_rxe_compl_done_o), 64'd0);
      check("rst_busy", 64'(wr_busy_o), 64'd0);
      check("rst_tag", 64'(req_tag_o), 64'd0);
      check("rst_addr", 64'(req_addr_o), 64'd0);
      rst_n = 1'b1;
      tick();

      // Memory is zero at start
      do_read(11'd100, 4'hF, 32'h0);

      // Full write then read at the register base
      d16 = 32'hCAFEF00C;
      do_write(11'(ADDR0_DW), 8'hFF, d16);
      do_read(11'(ADDR0_DW), 4'hF, 32'hCAFEF00C);

      // Partial write merges one byte; read masks lanes
      do_write(11'd5, 8'hFF, 32'h11223344);
      do_write(11'd5, 8'h02, 32'hAABBCCDD);
      do_read(11'd5, 4'hF, 32'h1122CC44);
      do_read(11'd5, 4'h1, 32'h00000044);
      do_read(11'd5, 4'hA, 32'h1100CC00);

      // Upper byte enables have no effect
      do_write(11'd7, 8'hF0, 32'hFFFFFFFF);
      do_read(11'd7, 4'hF, 32'h0);

      // Random writes including both address extremes
      addrs[0] = 11'd0; addrs[1] = 11'd2047;
      for (int i = 2; i < 6; i++) addrs[i] = 11'($urandom_range(32, 2046));
      foreach (addrs[i]) do_write(addrs[i], 8'($urandom), $urandom);
      foreach (addrs[i]) begin
         rbe = 4'($urandom);
         do_read(addrs[i], rbe, exp_rd(addrs[i], rbe));
      end

      // Completion request
      send_req(3'd0, 1'b0, 1'b0, 2'd0, 10'd1, 16'h0100, 8'd5, 8'h0F, 13'h10, 1'b1, 1'b1);
      check("np_ok_drop", 64'(rx_np_ok), 64'd0);
      repeat (10) tick();
      check("wait_state", 64'(dut.cmd_process_fsm_inst.state), 64'(STATE_WAIT_TX_CPLT));
      check("hold_tag", 64'(req_tag_o), 64'd5);
      check("hold_addr", 64'(req_addr_o), 64'h10);
      check("np_ok_held", 64'(rx_np_ok), 64'd0);
      check("one_cpl_pulse", 64'(cpl_pulses), 64'd1);

      // Second request while waiting is ignored
      send_req(3'd1, 1'b1, 1'b1, 2'd3, 10'd2, 16'hBEEF, 8'd9, 8'hFF, 13'h40, 1'b0, 1'b0);
      check("ignored_tag", 64'(req_tag_o), 64'd5);
      check("ignored_state", 64'(dut.cmd_process_fsm_inst.state), 64'(STATE_WAIT_TX_CPLT));
      repeat (2) tick();
      check("no_extra_cpl", 64'(cpl_pulses), 64'd1);

      // Write strobe while busy is dropped
      wr_addr_i = 11'd20; wr_be_i = 8'hFF; wr_data_i = 32'hA5A5_0001; wr_en_i = 1'b1;
      tick();
      check("drop_busy", 64'(wr_busy_o), 64'd1);
      wr_addr_i = 11'd21; wr_data_i = 32'h5A5A_0002;
      tick();
      wr_en_i = 1'b0;
      check("drop_busy_clr", 64'(wr_busy_o), 64'd0);
      model[20] = 32'hA5A5_0001;
      do_read(11'd20, 4'hF, 32'hA5A5_0001);
      do_read(11'd21, 4'hF, 32'h0);

      // TX done closes the completion
      txe_compl_done_i = 1'b1;
      tick();
      txe_compl_done_i = 1'b0;
      check("done_state", 64'(dut.cmd_process_fsm_inst.state), 64'(STATE_IDLE));
      check("done_pulse", 64'(to_rxe_compl_done_o), 64'd1);
      check("np_ok_back", 64'(rx_np_ok), 64'd1);
      tick();
      check("done_pulse_end", 64'(to_rxe_compl_done_o), 64'd0);

      // TX done outside the wait state is ignored
      txe_compl_done_i = 1'b1;
      tick();
      txe_compl_done_i = 1'b0;
      check("stray_done", 64'(to_rxe_compl_done_o), 64'd0);

      // Completion concurrent with a write, all header fields non-zero
      wr_addr_i = 11'd300; wr_be_i = 8'h0C; wr_data_i = 32'h1234_5678; wr_en_i = 1'b1;
      send_req(3'd6, 1'b1, 1'b1, 2'd2, 10'h3FF, 16'hA55A, 8'hA7, 8'hF3, 13'h1FFC, 1'b0, 1'b1);
      wr_en_i = 1'b0;
      model[300] = 32'h1234_0000;
      tick();
      do_read(11'd300, 4'hF, 32'h1234_0000);
      check("cpld_flag", 64'(req_compl_with_data_o), 64'd0);
      txe_compl_done_i = 1'b1;
      tick();
      txe_compl_done_i = 1'b0;
      check("done2_state", 64'(dut.cmd_process_fsm_inst.state), 64'(STATE_IDLE));

      // Asynchronous reset in the wait state with a write in flight
      send_req(3'd2, 1'b0, 1'b0, 2'd1, 10'd4, 16'h0042, 8'h33, 8'hFF, 13'h80, 1'b1, 1'b1);
      repeat (3) tick();
      wr_addr_i = 11'd30; wr_be_i = 8'hFF; wr_data_i = 32'hDEAD_BEEF; wr_en_i = 1'b1;
      tick();
      wr_en_i = 1'b0;
      check("pre_rst_state", 64'(dut.cmd_process_fsm_inst.state), 64'(STATE_WAIT_TX_CPLT));
      #2 rst_n = 1'b0;
      #1;
      check("arst_state", 64'(dut.cmd_process_fsm_inst.state), 64'(STATE_IDLE));
      check("arst_np_ok", 64'(rx_np_ok), 64'd1);
      check("arst_tag", 64'(req_tag_o), 64'd0);
      check("arst_addr", 64'(req_addr_o), 64'd0);
      check("arst_cpld", 64'(req_compl_with_data_o), 64'd0);
      check("arst_busy", 64'(wr_busy_o), 64'd0);
      check("arst_cpl", 64'(req_compl_o), 64'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      do_read(11'(ADDR0_DW), 4'hF, d16);
      check("post_rst_state", 64'(dut.cmd_process_fsm_inst.state), 64'(STATE_IDLE));

      check("cpl_total", 64'(cpl_pulses), 64'd3);
      check("done_total", 64'(done_pulses), 64'd2);
      check("cpl_q_empty", 64'(cpl_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
